// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic logic [6:0] SEG_OFF(input logic active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [7:0] AN_OFF(input logic active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_slot_timer.sv
// Slot timer: counts cycles within one digit slot and flags the end of
// the blanking interval and the end of the whole slot.
module scan_slot_timer #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);

  logic [CNT_W-1:0] count;

  // Free-running slot counter, restarted by the FSM at every slot boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign blank_end = (count == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = (count == CNT_W'(DIGIT_CYCLES - 1));

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Presents one digit code at a time to an external decoder and gates the
// decoder result and the matching anode onto the pins, with a blanking
// interval at the start of every digit slot.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [3:0]                    code_out,
  input  logic [6:0]                    seg_in,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  import seven_seg_pkg::*;

  localparam int                    IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            AN_OFF_ALL = AN_OFF(ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF_V   = AN_OFF_ALL[NUM_DIGITS-1:0];
  localparam logic [6:0]            SEG_OFF_V  = SEG_OFF(ACTIVE_LOW != 0);

  scan_state_t                 state;
  scan_state_t                 state_next;
  logic [4*NUM_DIGITS-1:0]     pending;
  logic [4*NUM_DIGITS-1:0]     display;
  logic                        timer_clear;
  logic                        blank_end;
  logic                        slot_end;
  logic                        slot_wrap;
  logic                        frame_wrap;
  logic [NUM_DIGITS-1:0]       onehot;
  logic [NUM_DIGITS-1:0]       an_next;
  logic [6:0]                  seg_next;

  scan_slot_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  // The decoder sees the current digit of the frame-stable display copy.
  assign code_out = display[DIGIT_W*digit_idx +: DIGIT_W];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: enable low always falls back to a dark IDLE.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = BLANK;
        BLANK:   if (blank_end) state_next = SHOW;
        SHOW:    if (slot_end) state_next = BLANK;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode, computed from the next state so the pins change on the
  // same edge as the state and a digit change always lands in BLANK.
  always_comb begin
    onehot            = '0;
    onehot[digit_idx] = 1'b1;
    slot_wrap         = (state == SHOW) && en && slot_end;
    frame_wrap        = slot_wrap && (digit_idx == LAST_IDX);
    timer_clear       = (state == IDLE) || (state_next == IDLE) || slot_wrap;
    an_next           = AN_OFF_V;
    seg_next          = SEG_OFF_V;
    if (state_next == SHOW) begin
      seg_next = seg_in;
      if (!blank_mask[digit_idx]) begin
        an_next = AN_OFF_V ^ onehot;
      end
    end
  end

  // Digit bookkeeping, tear-free display update at frame boundaries and
  // registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_idx  <= '0;
      pending    <= '0;
      display    <= '0;
      an_out     <= AN_OFF_V;
      seg_out    <= SEG_OFF_V;
      frame_done <= 1'b0;
    end else begin
      an_out     <= an_next;
      seg_out    <= seg_next;
      frame_done <= frame_wrap;
      if (load) begin
        pending <= digits_in;
      end
      if (!en) begin
        digit_idx <= '0;
      end else if (state == IDLE) begin
        digit_idx <= '0;
        display   <= pending;
      end else if (slot_wrap) begin
        if (frame_wrap) begin
          digit_idx <= '0;
          display   <= pending;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for the seven-segment scan controller, with a
// behavioural active-low decoder closing the code_out -> seg_in loop.
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [3:0]  code_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int          checkCount = 0;
  int          failCount  = 0;
  int          slot;
  int          phase;
  logic [15:0] pendModel;
  logic [15:0] curDisp;
  logic [3:0]  prevAn;
  logic [3:0]  expAn;
  logic [3:0]  expCode;
  logic [6:0]  expSeg;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(8),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .blank_mask(blank_mask),
    .code_out  (code_out),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low segment patterns (gfedcba) for hex codes 0..F.
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // External decoder model driving the same-cycle segment result.
  always_comb seg_in = decode(code_out);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic l,
                               input logic [15:0] d, input logic [3:0] m);
    rst        = r;
    en         = e;
    load       = l;
    digits_in  = d;
    blank_mask = m;
  endtask

  task automatic advanceClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkInvariants(input string tag);
    checkOutput({tag, " an_onehot0"}, 32'($countones(~an_out) <= 1), 32'd1);
    checkOutput({tag, " an_lit_switch"},
                32'((an_out != prevAn) && (an_out != 4'hF) && (prevAn != 4'hF)), 32'd0);
    prevAn = an_out;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0);
    advanceClock();
    advanceClock();
    checkOutput("reset an_out", 32'(an_out), 32'hF);
    checkOutput("reset seg_out", 32'(seg_out), 32'h7F);
    checkOutput("reset digit_idx", 32'(digit_idx), 32'd0);
    checkOutput("reset code_out", 32'(code_out), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    prevAn    = 4'hF;
    pendModel = 16'h0000;
    curDisp   = 16'h0000;

    // Enable and load on the same edge: the first frame shows the old (zero) pending value.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h4321, 4'h0);
    for (int k = 0; k <= 244; k++) begin
      advanceClock();
      if (k % 32 == 0) curDisp = pendModel;
      if (load) pendModel = digits_in;
      slot    = (k / 8) % 4;
      phase   = k % 8;
      expCode = curDisp[slot*4 +: 4];
      expAn   = 4'hF;
      expSeg  = 7'h7F;
      if (phase >= 2) begin
        expSeg = decode(expCode);
        if (!blank_mask[slot]) expAn[slot] = 1'b0;
      end
      checkOutput($sformatf("an_out k=%0d", k), 32'(an_out), 32'(expAn));
      checkOutput($sformatf("seg_out k=%0d", k), 32'(seg_out), 32'(expSeg));
      checkOutput($sformatf("code_out k=%0d", k), 32'(code_out), 32'(expCode));
      checkOutput($sformatf("digit_idx k=%0d", k), 32'(digit_idx), 32'(slot));
      checkOutput($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'((k > 0) && (k % 32 == 0)));
      checkInvariants($sformatf("dir k=%0d", k));
      case (k)
        0:   applyStimulus(1'b0, 1'b1, 1'b0, digits_in, blank_mask);
        64:  applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042, 4'b1100);
        65:  applyStimulus(1'b0, 1'b1, 1'b0, digits_in, blank_mask);
        127: applyStimulus(1'b0, 1'b1, 1'b0, digits_in, 4'b0000);
        140: applyStimulus(1'b0, 1'b1, 1'b1, 16'h9999, blank_mask);
        141: applyStimulus(1'b0, 1'b1, 1'b0, digits_in, blank_mask);
        191: applyStimulus(1'b0, 1'b1, 1'b1, 16'h5555, blank_mask);
        192: applyStimulus(1'b0, 1'b1, 1'b0, digits_in, blank_mask);
        244: applyStimulus(1'b0, 1'b0, 1'b0, digits_in, blank_mask);
        default: ;
      endcase
    end

    // Enable dropped during SHOW of digit 2.
    advanceClock();
    checkOutput("endrop an_out", 32'(an_out), 32'hF);
    checkOutput("endrop seg_out", 32'(seg_out), 32'h7F);
    checkOutput("endrop digit_idx", 32'(digit_idx), 32'd0);
    checkOutput("endrop frame_done", 32'(frame_done), 32'd0);
    advanceClock();
    checkOutput("idle an_out", 32'(an_out), 32'hF);
    checkOutput("idle seg_out", 32'(seg_out), 32'h7F);

    // Re-enable: digit 0 restarts with two blank cycles, showing pending 5555.
    applyStimulus(1'b0, 1'b1, 1'b0, digits_in, 4'h0);
    advanceClock();
    checkOutput("reen blank0 an_out", 32'(an_out), 32'hF);
    checkOutput("reen blank0 digit_idx", 32'(digit_idx), 32'd0);
    checkOutput("reen blank0 code_out", 32'(code_out), 32'd5);
    advanceClock();
    checkOutput("reen blank1 an_out", 32'(an_out), 32'hF);
    checkOutput("reen blank1 seg_out", 32'(seg_out), 32'h7F);
    advanceClock();
    checkOutput("reen show an_out", 32'(an_out), 32'hE);
    checkOutput("reen show seg_out", 32'(seg_out), 32'h12);

    // One-cycle reset in the middle of SHOW.
    applyStimulus(1'b1, 1'b1, 1'b0, digits_in, 4'h0);
    advanceClock();
    checkOutput("midrst an_out", 32'(an_out), 32'hF);
    checkOutput("midrst seg_out", 32'(seg_out), 32'h7F);
    checkOutput("midrst digit_idx", 32'(digit_idx), 32'd0);
    checkOutput("midrst code_out", 32'(code_out), 32'd0);
    checkOutput("midrst frame_done", 32'(frame_done), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, digits_in, 4'h0);
    for (int i = 0; i < 10; i++) advanceClock();
    checkOutput("postrst digit_idx", 32'(digit_idx), 32'd1);
    checkOutput("postrst code_out", 32'(code_out), 32'd0);
    checkOutput("postrst an_out", 32'(an_out), 32'hF);

    // Random traffic: anode exclusivity and dark-on-disable must always hold.
    prevAn = an_out;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                    16'($urandom), 4'($urandom));
      advanceClock();
      checkInvariants($sformatf("rnd i=%0d", i));
      if (!en) begin
        checkOutput($sformatf("rnd dark i=%0d", i),
                    32'({an_out, seg_out, frame_done}), 32'({4'hF, 7'h7F, 1'b0}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
